axi4_lite_top: RTL and testbench

Self-contained AXI4-Lite subsystem: a single-outstanding AXI4-Lite master FSM driven by simple start/done commands, wired internally to an AXI4-Lite slave holding a 32 x 32-bit register file. Serves as a bus-level loopback for exercising write and read transactions from a controller or bench. Internal AXI channels (AW, W, B, AR, R) are not exported.

---
 rtl/axi4_lite_top.sv | 320 ++++++++++++++++++++++++++++++++
 tb/tb_axi4_lite_top.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_lite_top.sv
`default_nettype none
// ============================================================================
// Module   : axi4_lite_top
// Brief    : Single-outstanding AXI4-Lite master looped back to a 32-bit
//            register-file slave. Optional macro AXI_LITE_RESP_PORTS_EN
//            exports the last BRESP/RRESP as write_resp/read_resp.
// Revision : 1.0
// ============================================================================
module axi4_lite_top #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              start_write,
    input  logic              start_read,
    input  logic [DATA_W-1:0] write_data,
    input  logic [ADDR_W-1:0] write_address_M,
    input  logic [ADDR_W-1:0] read_address,
    output logic [DATA_W-1:0] read_data,
    output logic              write_done,
    output logic              read_done
`ifdef AXI_LITE_RESP_PORTS_EN
    ,
    output logic [1:0]        write_resp,
    output logic [1:0]        read_resp
`endif
);

    localparam int                c_idx_w       = $clog2(NUM_REGS);
    localparam int                c_strb_w      = DATA_W / 8;
    localparam logic [ADDR_W:0]   c_map_bytes   = (ADDR_W+1)'(NUM_REGS * 4);
    localparam logic [1:0]        c_resp_okay   = 2'b00;
    localparam logic [1:0]        c_resp_slverr = 2'b10;

    typedef enum logic [1:0] {
        WR_IDLE      = 2'd0,
        WR_ADDR_DATA = 2'd1,
        WR_WAIT_B    = 2'd2
    } wr_state_t;

    typedef enum logic [1:0] {
        RD_IDLE   = 2'd0,
        RD_ADDR   = 2'd1,
        RD_WAIT_R = 2'd2
    } rd_state_t;

    // Internal AXI4-Lite channels
    logic [ADDR_W-1:0]   w_awaddr;
    logic [2:0]          w_awprot;
    logic                w_awvalid;
    logic                r_awready;
    logic [DATA_W-1:0]   w_wdata;
    logic [c_strb_w-1:0] w_wstrb;
    logic                w_wvalid;
    logic                r_wready;
    logic [1:0]          r_bresp;
    logic                r_bvalid;
    logic                w_bready;
    logic [ADDR_W-1:0]   w_araddr;
    logic [2:0]          w_arprot;
    logic                w_arvalid;
    logic                r_arready;
    logic [DATA_W-1:0]   r_rdata;
    logic [1:0]          r_rresp;
    logic                r_rvalid;
    logic                w_rready;

    logic w_aw_w_hs;
    logic w_b_hs;
    logic w_ar_hs;
    logic w_r_hs;

    assign w_aw_w_hs = w_awvalid && r_awready && w_wvalid && r_wready;
    assign w_b_hs    = r_bvalid && w_bready;
    assign w_ar_hs   = w_arvalid && r_arready;
    assign w_r_hs    = r_rvalid && w_rready;

    // ------------------------------------------------------------------
    // Master: write FSM
    // ------------------------------------------------------------------
    wr_state_t         r_wr_state;
    wr_state_t         w_wr_state_nxt;
    logic              w_wr_accept;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;
    logic              r_write_done;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_wr_state <= WR_IDLE;
        end else begin
            r_wr_state <= w_wr_state_nxt;
        end
    end

    always_comb begin
        w_wr_state_nxt = r_wr_state;
        w_wr_accept    = 1'b0;
        w_awvalid      = 1'b0;
        w_wvalid       = 1'b0;
        w_bready       = 1'b0;
        case (r_wr_state)
            WR_IDLE: begin
                if (start_write) begin
                    w_wr_accept    = 1'b1;
                    w_wr_state_nxt = WR_ADDR_DATA;
                end
            end
            WR_ADDR_DATA: begin
                w_awvalid = 1'b1;
                w_wvalid  = 1'b1;
                if (w_aw_w_hs) begin
                    w_wr_state_nxt = WR_WAIT_B;
                end
            end
            WR_WAIT_B: begin
                w_bready = 1'b1;
                if (r_bvalid) begin
                    w_wr_state_nxt = WR_IDLE;
                end
            end
            default: w_wr_state_nxt = WR_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_write_done <= 1'b0;
        end else begin
            if (w_wr_accept) begin
                r_wr_addr <= write_address_M;
                r_wr_data <= write_data;
            end
            r_write_done <= w_b_hs;
        end
    end

    assign w_awaddr   = r_wr_addr;
    assign w_wdata    = r_wr_data;
    assign w_wstrb    = '1;
    assign w_awprot   = 3'b000;
    assign write_done = r_write_done;

    // ------------------------------------------------------------------
    // Master: read FSM
    // ------------------------------------------------------------------
    rd_state_t         r_rd_state;
    rd_state_t         w_rd_state_nxt;
    logic              w_rd_accept;
    logic [ADDR_W-1:0] r_rd_addr;
    logic [DATA_W-1:0] r_read_data;
    logic              r_read_done;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_rd_state <= RD_IDLE;
        end else begin
            r_rd_state <= w_rd_state_nxt;
        end
    end

    always_comb begin
        w_rd_state_nxt = r_rd_state;
        w_rd_accept    = 1'b0;
        w_arvalid      = 1'b0;
        w_rready       = 1'b0;
        case (r_rd_state)
            RD_IDLE: begin
                if (start_read) begin
                    w_rd_accept    = 1'b1;
                    w_rd_state_nxt = RD_ADDR;
                end
            end
            RD_ADDR: begin
                w_arvalid = 1'b1;
                if (w_ar_hs) begin
                    w_rd_state_nxt = RD_WAIT_R;
                end
            end
            RD_WAIT_R: begin
                w_rready = 1'b1;
                if (r_rvalid) begin
                    w_rd_state_nxt = RD_IDLE;
                end
            end
            default: w_rd_state_nxt = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_rd_addr   <= '0;
            r_read_data <= '0;
            r_read_done <= 1'b0;
        end else begin
            if (w_rd_accept) begin
                r_rd_addr <= read_address;
            end
            if (w_r_hs) begin
                r_read_data <= r_rdata;
            end
            r_read_done <= w_r_hs;
        end
    end

    assign w_araddr  = r_rd_addr;
    assign w_arprot  = 3'b000;
    assign read_data = r_read_data;
    assign read_done = r_read_done;

    // ------------------------------------------------------------------
    // Slave: register file with write and read channels
    // ------------------------------------------------------------------
    logic [DATA_W-1:0]  r_regs [NUM_REGS];
    logic               w_wr_addr_ok;
    logic               w_rd_addr_ok;
    logic [c_idx_w-1:0] w_wr_idx;
    logic [c_idx_w-1:0] w_rd_idx;
    logic [DATA_W-1:0]  w_wr_merged;

    assign w_wr_addr_ok = (w_awaddr[1:0] == 2'b00) && ({1'b0, w_awaddr} < c_map_bytes);
    assign w_rd_addr_ok = (w_araddr[1:0] == 2'b00) && ({1'b0, w_araddr} < c_map_bytes);
    assign w_wr_idx     = w_awaddr[c_idx_w+1:2];
    assign w_rd_idx     = w_araddr[c_idx_w+1:2];

    always_comb begin
        w_wr_merged = r_regs[w_wr_idx];
        for (int b = 0; b < c_strb_w; b++) begin
            if (w_wstrb[b]) begin
                w_wr_merged[8*b +: 8] = w_wdata[8*b +: 8];
            end
        end
    end

    // Ready is raised one cycle after both VALIDs so the handshake lands on
    // the second edge; it is never raised while a B response is outstanding.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= c_resp_okay;
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            if (w_aw_w_hs) begin
                r_awready <= 1'b0;
                r_wready  <= 1'b0;
                r_bvalid  <= 1'b1;
                r_bresp   <= w_wr_addr_ok ? c_resp_okay : c_resp_slverr;
                if (w_wr_addr_ok) begin
                    r_regs[w_wr_idx] <= w_wr_merged;
                end
            end else if (w_awvalid && w_wvalid && !r_awready && !r_bvalid) begin
                r_awready <= 1'b1;
                r_wready  <= 1'b1;
            end
            if (w_b_hs) begin
                r_bvalid <= 1'b0;
            end
        end
    end

    // A same-cycle write to the same register is not yet visible here.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= c_resp_okay;
        end else begin
            if (w_ar_hs) begin
                r_arready <= 1'b0;
                r_rvalid  <= 1'b1;
                r_rdata   <= w_rd_addr_ok ? r_regs[w_rd_idx] : '0;
                r_rresp   <= w_rd_addr_ok ? c_resp_okay : c_resp_slverr;
            end else if (w_arvalid && !r_arready && !r_rvalid) begin
                r_arready <= 1'b1;
            end
            if (w_r_hs) begin
                r_rvalid <= 1'b0;
            end
        end
    end

`ifdef AXI_LITE_RESP_PORTS_EN
    logic [1:0] r_write_resp;
    logic [1:0] r_read_resp;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_write_resp <= c_resp_okay;
            r_read_resp  <= c_resp_okay;
        end else begin
            if (w_b_hs) begin
                r_write_resp <= r_bresp;
            end
            if (w_r_hs) begin
                r_read_resp <= r_rresp;
            end
        end
    end

    assign write_resp = r_write_resp;
    assign read_resp  = r_read_resp;

    logic w_unused_prot;
    assign w_unused_prot = ^{w_awprot, w_arprot};
`else
    logic w_unused_resp;
    assign w_unused_resp = ^{w_awprot, w_arprot, r_bresp, r_rresp};
`endif

endmodule
`default_nettype wire

// File: tb/tb_axi4_lite_top.sv
`default_nettype none
// Bench for axi4_lite_top: directed and random transactions checked against
// an array model of the register file and the protocol timing rules.
module tb_axi4_lite_top;

    logic        clk = 1'b0;
    logic        arst_n;
    logic        start_write;
    logic        start_read;
    logic [31:0] write_data;
    logic [31:0] write_address_M;
    logic [31:0] read_address;
    logic [31:0] read_data;
    logic        write_done;
    logic        read_done;
`ifdef AXI_LITE_RESP_PORTS_EN
    logic [1:0]  write_resp;
    logic [1:0]  read_resp;
`endif

    always #5 clk = ~clk;

    axi4_lite_top dut (
        .clk             (clk),
        .arst_n          (arst_n),
        .start_write     (start_write),
        .start_read      (start_read),
        .write_data      (write_data),
        .write_address_M (write_address_M),
        .read_address    (read_address),
        .read_data       (read_data),
        .write_done      (write_done),
        .read_done       (read_done)
`ifdef AXI_LITE_RESP_PORTS_EN
        ,
        .write_resp      (write_resp),
        .read_resp       (read_resp)
`endif
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] mem [32];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit addr_ok(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (a < 32'd128);
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        return addr_ok(a) ? mem[a[6:2]] : 32'h0;
    endfunction

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 3))
            0, 1:    return {25'b0, 5'($urandom_range(0, 31)), 2'b00};
            2:       return {25'b0, 5'($urandom_range(0, 31)), 2'($urandom_range(1, 3))};
            default: return 32'd128 + 32'($urandom_range(0, 1000));
        endcase
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_read_data"}, read_data, 32'h0);
        check({tag, "_write_done"}, {31'b0, write_done}, 32'h0);
        check({tag, "_read_done"}, {31'b0, read_done}, 32'h0);
`ifdef AXI_LITE_RESP_PORTS_EN
        check({tag, "_write_resp"}, {30'b0, write_resp}, 32'h0);
        check({tag, "_read_resp"}, {30'b0, read_resp}, 32'h0);
`endif
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                            input bit dup, input logic [31:0] a2, input logic [31:0] d2);
        int lat;
        int extra;
        @(negedge clk);
        start_write = 1'b1; write_address_M = a; write_data = d;
        @(negedge clk);
        if (dup) begin
            start_write = 1'b1; write_address_M = a2; write_data = d2;
            @(negedge clk);
        end
        start_write = 1'b0; write_address_M = $urandom; write_data = $urandom;
        lat = 0;
        while (write_done !== 1'b1 && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        check("wr_latency", 32'(lat), dup ? 32'd2 : 32'd3);
        if (addr_ok(a)) mem[a[6:2]] = d;
`ifdef AXI_LITE_RESP_PORTS_EN
        check("wr_resp", {30'b0, write_resp}, addr_ok(a) ? 32'd0 : 32'd2);
`endif
        extra = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (write_done !== 1'b0) extra++;
        end
        check("wr_single_pulse", 32'(extra), 32'd0);
    endtask

    task automatic do_read(input logic [31:0] a, input bit dup, input logic [31:0] a2);
        int lat;
        int extra;
        logic [31:0] exp;
        exp = model_read(a);
        @(negedge clk);
        start_read = 1'b1; read_address = a;
        @(negedge clk);
        if (dup) begin
            start_read = 1'b1; read_address = a2;
            @(negedge clk);
        end
        start_read = 1'b0; read_address = $urandom;
        lat = 0;
        while (read_done !== 1'b1 && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        check("rd_latency", 32'(lat), dup ? 32'd2 : 32'd3);
        check("rd_data", read_data, exp);
`ifdef AXI_LITE_RESP_PORTS_EN
        check("rd_resp", {30'b0, read_resp}, addr_ok(a) ? 32'd0 : 32'd2);
`endif
        extra = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (read_done !== 1'b0) extra++;
        end
        check("rd_single_pulse", 32'(extra), 32'd0);
        check("rd_data_hold", read_data, exp);
    endtask

    // Write and read launched on the same edge: the read must see the old value.
    task automatic do_overlap(input logic [31:0] a, input logic [31:0] d);
        bit          wseen;
        bit          rseen;
        int          cyc;
        logic [31:0] got;
        logic [31:0] old;
        old = model_read(a);
        @(negedge clk);
        start_write = 1'b1; write_address_M = a; write_data = d;
        start_read  = 1'b1; read_address = a;
        @(negedge clk);
        start_write = 1'b0; start_read = 1'b0;
        wseen = 1'b0; rseen = 1'b0; cyc = 0; got = 32'hDEAD_BEEF;
        while (!(wseen && rseen) && cyc < 12) begin
            @(negedge clk);
            cyc++;
            if (write_done === 1'b1) wseen = 1'b1;
            if (read_done === 1'b1) begin
                rseen = 1'b1;
                got = read_data;
            end
        end
        check("ovl_both_done", 32'(cyc), 32'd3);
        check("ovl_old_value", got, old);
        if (addr_ok(a)) mem[a[6:2]] = d;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        arst_n = 1'b0;
        start_write = 1'b0; start_read = 1'b0;
        write_data = '0; write_address_M = '0; read_address = '0;
        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        arst_n = 1'b1;
        @(negedge clk);

        do_write(32'h10, 32'hA5A5A5A5, 1'b0, 32'h0, 32'h0);
        do_read(32'h10, 1'b0, 32'h0);

        do_write(32'h20, 32'h12345678, 1'b0, 32'h0, 32'h0);
        do_read(32'h20, 1'b0, 32'h0);
        do_read(32'h10, 1'b0, 32'h0);

        do_write(32'h13, 32'hCAFEBABE, 1'b0, 32'h0, 32'h0);
        do_read(32'h10, 1'b0, 32'h0);
        do_read(32'h14, 1'b0, 32'h0);

        do_read(32'h0000FFFF, 1'b0, 32'h0);

        do_write(32'h30, 32'h11223344, 1'b1, 32'h40, 32'h55667788);
        do_read(32'h30, 1'b0, 32'h0);
        do_read(32'h40, 1'b0, 32'h0);
        do_read(32'h30, 1'b1, 32'h20);

        do_write(32'h7C, 32'hFEEDF00D, 1'b0, 32'h0, 32'h0);
        do_read(32'h7C, 1'b0, 32'h0);
        do_write(32'h80, 32'h0BADF00D, 1'b0, 32'h0, 32'h0);
        do_read(32'h80, 1'b0, 32'h0);
        do_read(32'h00, 1'b0, 32'h0);

        do_overlap(32'h10, 32'h5A5A0F0F);
        do_read(32'h10, 1'b0, 32'h0);

        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 2))
                0:       do_write(rand_addr(), $urandom, 1'b0, 32'h0, 32'h0);
                1:       do_read(rand_addr(), 1'b0, 32'h0);
                default: do_overlap(rand_addr(), $urandom);
            endcase
        end

        // Reset while the write to 0x50 sits in WAIT_B
        @(negedge clk);
        start_write = 1'b1; write_address_M = 32'h50; write_data = 32'h99887766;
        @(negedge clk);
        start_write = 1'b0;
        @(negedge clk);
        @(negedge clk);
        arst_n = 1'b0;
        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        @(negedge clk);
        check_all_zero("midreset");
        @(negedge clk);
        arst_n = 1'b1;
        @(negedge clk);
        check("midreset_no_done", {31'b0, write_done}, 32'h0);
        do_read(32'h50, 1'b0, 32'h0);
        do_read(32'h10, 1'b0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
